// File: rtl/fir_engine_pkg.sv
// Shared types for the FIR engine: control/flag structs and FSM state encoding.
package fir_package;

  localparam int NB_TAPS_DEF = 8;
  localparam int SHIFT_W     = 5;

  typedef struct packed {
    logic               start;
    logic [15:0]        len;
    logic [SHIFT_W-1:0] shift;
  } ctrl_engine_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        sat;
    logic [15:0] cnt;
  } flags_engine_t;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} engine_state_t;

endpackage

// File: rtl/fir_engine_mac.sv
// Combinational FIR kernel: NB_TAPS signed multipliers feeding a balanced adder tree.
// No latency, no flow control; taps[0] is the newest sample.
module fir_engine_mac #(
  parameter int NB_TAPS  = 8,
  parameter int SAMPLE_W = 16,
  localparam int ACC_W   = 2*SAMPLE_W + $clog2(NB_TAPS) + 1
) (
  input  logic [NB_TAPS-1:0][SAMPLE_W-1:0] coeff,
  input  logic [NB_TAPS-1:0][SAMPLE_W-1:0] taps,
  output logic signed [ACC_W-1:0]          sum
);

  // Heap-ordered tree: leaves at NB_TAPS..2*NB_TAPS-1, root at 1.
  logic signed [ACC_W-1:0] node [1:2*NB_TAPS-1];

  for (genvar k = 0; k < NB_TAPS; k++) begin : g_mul
    logic signed [2*SAMPLE_W-1:0] prod;
    assign prod             = $signed(coeff[k]) * $signed(taps[k]);
    assign node[NB_TAPS+k]  = ACC_W'(prod);
  end

  for (genvar i = 1; i < NB_TAPS; i++) begin : g_add
    assign node[i] = node[2*i] + node[2*i+1];
  end

  assign sum = node[1];

endmodule

// File: rtl/fir_engine.sv
// FIR engine: loads NB_TAPS coefficients per job, then emits one saturated result per (a,c) pair.
// One cycle a/c-to-d latency; a/c stall while the output register holds an unaccepted result.
module fir_engine
  import fir_package::*;
#(
  parameter int NB_TAPS  = NB_TAPS_DEF,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic [DATA_W-1:0]   b_data_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [DATA_W-1:0]   c_data_i,
  input  logic                c_valid_i,
  output logic                c_ready_o,
  output logic [DATA_W-1:0]   d_data_o,
  output logic [DATA_W/8-1:0] d_strb_o,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  input  ctrl_engine_t        ctrl_i,
  output flags_engine_t       flags_o
);

  localparam int ACC_W = 2*SAMPLE_W + $clog2(NB_TAPS) + 1;
  localparam int IDX_W = $clog2(NB_TAPS);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  engine_state_t state_q, state_d;

  logic [15:0]                       len_q, cnt_q;
  logic [SHIFT_W-1:0]                shift_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [NB_TAPS-1:0][SAMPLE_W-1:0]  coeff_q;
  logic [NB_TAPS-2:0][SAMPLE_W-1:0]  delay_q;
  logic [NB_TAPS-1:0][SAMPLE_W-1:0]  taps;
  logic                              sat_q;
  logic [DATA_W-1:0]                 out_q;
  logic                              out_vld_q;

  logic                         act, fire;
  logic signed [ACC_W-1:0]      mac_sum, acc, shifted;
  logic [ACC_W-DATA_W:0]        hi_bits;
  logic                         ovf;
  logic [DATA_W-1:0]            result;
  logic                         unused_upper;

  assign act       = enable_i & ~clear_i;
  assign b_ready_o = act & (state_q == LOAD);
  assign fire      = act & (state_q == RUN) & a_valid_i & c_valid_i
                   & (~out_vld_q | d_ready_i) & (cnt_q < len_q);
  assign a_ready_o = fire;
  assign c_ready_o = fire;

  assign d_data_o  = out_q;
  assign d_strb_o  = '1;
  assign d_valid_o = out_vld_q;

  assign flags_o.busy = (state_q == LOAD) | (state_q == RUN) | (state_q == DRAIN);
  assign flags_o.done = (state_q == DONE);
  assign flags_o.sat  = sat_q;
  assign flags_o.cnt  = cnt_q;

  assign unused_upper = ^{a_data_i[DATA_W-1:SAMPLE_W], b_data_i[DATA_W-1:SAMPLE_W]};

  // Newest sample enters at tap 0 combinationally, so the result is ready in the fire cycle.
  assign taps = {delay_q, a_data_i[SAMPLE_W-1:0]};

  fir_engine_mac #(
    .NB_TAPS  (NB_TAPS),
    .SAMPLE_W (SAMPLE_W)
  ) u_mac (
    .coeff (coeff_q),
    .taps  (taps),
    .sum   (mac_sum)
  );

  assign acc     = mac_sum + ACC_W'($signed(c_data_i));
  assign shifted = acc >>> shift_q;
  assign hi_bits = shifted[ACC_W-1:DATA_W-1];
  assign ovf     = ~((&hi_bits) | ~(|hi_bits));
  assign result  = ovf ? (shifted[ACC_W-1] ? SAT_MIN : SAT_MAX) : shifted[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ctrl_i.start) state_d = LOAD;
      LOAD:    if (b_valid_i && idx_q == IDX_W'(NB_TAPS-1)) state_d = RUN;
      RUN:     if (cnt_q == len_q) state_d = DRAIN;
      DRAIN:   if (!out_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         state_q <= IDLE;
    else if (clear_i)  state_q <= IDLE;
    else if (enable_i) state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      coeff_q   <= '0;
      delay_q   <= '0;
      sat_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (clear_i) begin
      len_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      coeff_q   <= '0;
      delay_q   <= '0;
      sat_q     <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (enable_i) begin
      if (state_q == IDLE && ctrl_i.start) begin
        len_q   <= ctrl_i.len;
        shift_q <= ctrl_i.shift;
        cnt_q   <= '0;
        idx_q   <= '0;
        delay_q <= '0;
        sat_q   <= 1'b0;
      end
      if (b_ready_o && b_valid_i) begin
        coeff_q[idx_q] <= b_data_i[SAMPLE_W-1:0];
        idx_q          <= idx_q + IDX_W'(1);
      end
      if (fire) begin
        delay_q   <= taps[NB_TAPS-2:0];
        out_q     <= result;
        out_vld_q <= 1'b1;
        cnt_q     <= cnt_q + 16'd1;
        sat_q     <= sat_q | ovf;
      end else if (out_vld_q && d_ready_i) begin
        out_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_engine.sv
// Self-checking bench for fir_engine: table of jobs with hand-derived results, scoreboard on stream d.
module tb_fir_engine;
  import fir_package::*;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [31:0] a_data, b_data, c_data, d_data;
  logic        a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready;
  logic [3:0]  d_strb;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;

  always #5 clk = ~clk;

  fir_engine dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .a_data_i(a_data), .a_valid_i(a_valid), .a_ready_o(a_ready),
    .b_data_i(b_data), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .c_data_i(c_data), .c_valid_i(c_valid), .c_ready_o(c_ready),
    .d_data_o(d_data), .d_strb_o(d_strb), .d_valid_o(d_valid), .d_ready_i(d_ready),
    .ctrl_i(ctrl), .flags_o(flags)
  );

  typedef struct {
    int coeff[8];
    int samp[10];
    int cval;
    int shift;
    int len;
    int exp[10];
    bit exp_sat;
  } vec_t;

  vec_t vec[6];
  int   sb[$];
  int   checks = 0, errors = 0;
  int   d_beats = 0, done_cnt = 0, a_hs = 0, bp_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event absent, expected it within bound at %0t", name, $time);
  endtask

  task automatic monitor();
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (d_valid && d_ready && !clear) begin
          d_beats++;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_d_beat: got 0x%08h, expected no beat at %0t", d_data, $time);
          end else begin
            chk("d_data", d_data, sb.pop_front());
          end
          chk("d_strb", 32'(d_strb), 32'hF);
        end
        if (hold && d_valid) chk("d_stable", d_data, held);
        hold = d_valid && !d_ready && !clear;
        held = d_data;
        if (hold) chk("ac_rdy_while_held", 32'(a_ready | c_ready), 0);
        if (a_ready || c_ready) chk("a_c_rdy_pair", 32'(a_ready), 32'(c_ready));
        if (flags.done) done_cnt++;
        if (a_valid && a_ready) a_hs++;
      end
    end
  endtask

  task automatic rdy_gen();
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      d_ready = (bp_mode == 0) || (cyc % 3 == 0);
    end
  endtask

  // Inputs are already driven after a posedge; returns just after the accepting edge.
  task automatic wait_rdy(input int which);
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if ((which == 0 && b_ready) || (which == 1 && a_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail(which == 0 ? "b_handshake" : "ac_handshake");
    @(posedge clk); #1;
  endtask

  task automatic start_load(input int v, input int len);
    @(posedge clk); #1;
    ctrl.start = 1'b1;
    ctrl.len   = 16'(len);
    ctrl.shift = SHIFT_W'(vec[v].shift);
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(flags.busy), 1);
    chk("start_sat_clr", 32'(flags.sat), 0);
    chk("start_cnt", 32'(flags.cnt), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1;
      b_data  = {16'($urandom), vec[v].coeff[k][15:0]};
      wait_rdy(0);
    end
    b_valid = 1'b0;
  endtask

  task automatic wait_done(input int done0);
    int t = 0;
    while (done_cnt == done0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input int v, input int bp);
    int done0 = done_cnt;
    int d0    = d_beats;
    bp_mode = bp;
    start_load(v, vec[v].len);
    for (int i = 0; i < vec[v].len; i++) begin
      if (bp != 0) begin
        a_valid = 1'b0;
        c_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      a_valid = 1'b1;
      c_valid = 1'b1;
      a_data  = {16'($urandom), vec[v].samp[i][15:0]};
      c_data  = vec[v].cval;
      sb.push_back(vec[v].exp[i]);
      wait_rdy(1);
    end
    a_valid = 1'b0;
    c_valid = 1'b0;
    wait_done(done0);
    chk($sformatf("done_pulses[%0d]", v), 32'(done_cnt - done0), 1);
    chk($sformatf("d_beat_count[%0d]", v), 32'(d_beats - d0), 32'(vec[v].len));
    chk($sformatf("sb_empty[%0d]", v), 32'(sb.size()), 0);
    chk($sformatf("sat_flag[%0d]", v), 32'(flags.sat), 32'(vec[v].exp_sat));
    chk($sformatf("cnt_flag[%0d]", v), 32'(flags.cnt), 32'(vec[v].len));
    chk($sformatf("busy_after[%0d]", v), 32'(flags.busy), 0);
  endtask

  initial begin
    int d0, done0, a0, i, t;

    for (int k = 0; k < 8; k++) begin
      vec[0].coeff[k] = 1;
      vec[2].coeff[k] = 32'h7FFF;
      vec[3].coeff[k] = 1;
      vec[4].coeff[k] = 2;
      vec[5].coeff[k] = -32768;
    end
    vec[0].samp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vec[0].len  = 10;
    vec[0].exp  = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52};
    vec[1].coeff = '{1, 2, 3, 4, 5, 6, 7, 8};
    vec[1].samp  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[1].cval  = 5;
    vec[1].len   = 10;
    vec[1].exp   = '{6, 7, 8, 9, 10, 11, 12, 13, 5, 5};
    vec[2].samp    = '{default: 32'h7FFF};
    vec[2].cval    = 32'h7FFFFFFF;
    vec[2].len     = 8;
    vec[2].exp     = '{default: 32'h7FFFFFFF};
    vec[2].exp_sat = 1'b1;
    vec[3].samp  = '{default: -4};
    vec[3].shift = 2;
    vec[3].len   = 8;
    vec[3].exp   = '{-1, -2, -3, -4, -5, -6, -7, -8, 0, 0};
    vec[4].samp  = '{default: 3};
    vec[4].cval  = -100;
    vec[4].shift = 1;
    vec[4].len   = 4;
    vec[4].exp   = '{-47, -44, -41, -38, 0, 0, 0, 0, 0, 0};
    vec[5].samp    = '{default: 32'h7FFF};
    vec[5].cval    = 32'h80000000;
    vec[5].len     = 2;
    vec[5].exp     = '{default: 32'h80000000};
    vec[5].exp_sat = 1'b1;

    rst = 1'b1; enable = 1'b1; clear = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b1;
    a_data = '0; b_data = '0; c_data = '0;
    ctrl = '0;

    fork
      monitor();
      rdy_gen();
      begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_readies", 32'({a_ready, b_ready, c_ready}), 0);
    chk("rst_flags", 32'(flags), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) run_job(v, 0);
    run_job(0, 1);

    // len == 0: coefficients load, done pulses, a/c never consumed even though offered.
    bp_mode = 0;
    d0 = d_beats; done0 = done_cnt; a0 = a_hs;
    a_valid = 1'b1; c_valid = 1'b1; a_data = 32'd7; c_data = '0;
    start_load(0, 0);
    wait_done(done0);
    chk("len0_done", 32'(done_cnt - done0), 1);
    chk("len0_no_d", 32'(d_beats - d0), 0);
    chk("len0_no_ac", 32'(a_hs - a0), 0);
    chk("len0_idle", 32'(flags.busy), 0);
    a_valid = 1'b0; c_valid = 1'b0;

    // Soft clear after the third result beat.
    d0 = d_beats; done0 = done_cnt; i = 0; t = 0;
    start_load(0, 10);
    while (d_beats < d0 + 3 && t < 200) begin
      a_valid = (i < 10);
      c_valid = (i < 10);
      a_data  = (i < 10) ? vec[0].samp[i] : 0;
      c_data  = 0;
      @(negedge clk);
      t++;
      if (a_ready) begin
        sb.push_back(vec[0].exp[i]);
        i++;
      end
      @(posedge clk); #1;
    end
    if (t >= 200) fail("clear_three_beats");
    clear = 1'b1; a_valid = 1'b0; c_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_d_valid", 32'(d_valid), 0);
    chk("clear_busy", 32'(flags.busy), 0);
    chk("clear_cnt", 32'(flags.cnt), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("clear_no_done", 32'(done_cnt - done0), 0);
    chk("clear_beats", 32'(d_beats - d0), 3);
    sb.delete();
    run_job(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
